// File: rtl/video_mode_sequencer_if.sv
// Request and generator-control signals between the mode sequencer and its neighbours.
// The slave side is the sequencer; the master side is the menu logic plus the HDMI clock generator.
interface video_mode_sequencer_if;
  logic [3:0] mode_req;
  logic       mode_req_valid;
  logic       lock_i;
  logic [3:0] clock_config;
  logic       vc_rstn;
  logic       busy;
  logic       mode_ack;
  logic       mode_err;
  logic       lock_lost;

  modport master (
    output mode_req, mode_req_valid, lock_i,
    input  clock_config, vc_rstn, busy, mode_ack, mode_err, lock_lost
  );

  modport slave (
    input  mode_req, mode_req_valid, lock_i,
    output clock_config, vc_rstn, busy, mode_ack, mode_err, lock_lost
  );
endinterface

// File: rtl/video_mode_sequencer.sv
// Sequences HDMI pixel-clock mode changes: reset the generator, switch config, settle,
// release, then wait for a stable lock with timeout/retry and lock-loss recovery.
module video_mode_sequencer #(
  parameter logic [3:0] DEFAULT_CONFIG = 4'd0,
  parameter int QUIESCE_CYCLES = 64,
  parameter int SETTLE_CYCLES  = 256,
  parameter int LOCK_STABLE    = 1024,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 21
) (
  input logic clk27,
  input logic rstn,
  video_mode_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, QUIESCE, SWITCH, WAIT_LOCK, ERROR} state_t;

  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] Q_LAST   = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] S_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [STB_W-1:0] stable;
  logic [RTY_W-1:0] retry;
  logic [RTY_W-1:0] retry_inc;
  logic [3:0]       target;
  logic             pend_valid;
  logic [3:0]       pend_mode;
  logic [1:0]       loss_cnt;
  logic             take_valid;
  logic [3:0]       take_mode;

  logic [3:0] clock_config_r;
  logic       vc_rstn_r, busy_r, mode_ack_r, mode_err_r, lock_lost_r;

  assign bus.clock_config = clock_config_r;
  assign bus.vc_rstn      = vc_rstn_r;
  assign bus.busy         = busy_r;
  assign bus.mode_ack     = mode_ack_r;
  assign bus.mode_err     = mode_err_r;
  assign bus.lock_lost    = lock_lost_r;

  // A request arriving in the same cycle as success/error entry counts as the latest pending one.
  assign take_valid = bus.mode_req_valid | pend_valid;
  assign take_mode  = bus.mode_req_valid ? bus.mode_req : pend_mode;
  assign retry_inc  = retry + RTY_W'(1);

  always_ff @(posedge clk27 or negedge rstn) begin
    if (!rstn) begin
      state          <= QUIESCE;
      cnt            <= '0;
      stable         <= '0;
      retry          <= '0;
      target         <= DEFAULT_CONFIG;
      pend_valid     <= 1'b0;
      pend_mode      <= DEFAULT_CONFIG;
      loss_cnt       <= 2'd0;
      clock_config_r <= DEFAULT_CONFIG;
      vc_rstn_r      <= 1'b0;
      busy_r         <= 1'b1;
      mode_ack_r     <= 1'b0;
      mode_err_r     <= 1'b0;
      lock_lost_r    <= 1'b0;
    end else begin
      mode_ack_r  <= 1'b0;
      lock_lost_r <= 1'b0;
      loss_cnt    <= 2'd0;
      if (busy_r && bus.mode_req_valid) begin
        pend_valid <= 1'b1;
        pend_mode  <= bus.mode_req;
      end

      case (state)
        IDLE: begin
          if (!bus.lock_i && loss_cnt != 2'd3) loss_cnt <= loss_cnt + 2'd1;
          if (!bus.lock_i && loss_cnt == 2'd3) begin
            lock_lost_r <= 1'b1;
            retry       <= '0;
            cnt         <= '0;
            vc_rstn_r   <= 1'b0;
            busy_r      <= 1'b1;
            state       <= QUIESCE;
            if (bus.mode_req_valid) target <= bus.mode_req;
          end else if (bus.mode_req_valid && bus.mode_req == clock_config_r) begin
            mode_ack_r <= 1'b1;
          end else if (bus.mode_req_valid) begin
            target    <= bus.mode_req;
            retry     <= '0;
            cnt       <= '0;
            vc_rstn_r <= 1'b0;
            busy_r    <= 1'b1;
            state     <= QUIESCE;
          end
        end

        QUIESCE: begin
          if (cnt == Q_LAST) begin
            clock_config_r <= target;
            cnt            <= '0;
            state          <= SWITCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SWITCH: begin
          if (cnt == S_LAST) begin
            vc_rstn_r <= 1'b1;
            cnt       <= '0;
            stable    <= '0;
            state     <= WAIT_LOCK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (bus.lock_i && stable == STB_LAST) begin
            mode_ack_r <= 1'b1;
            mode_err_r <= 1'b0;
            retry      <= '0;
            cnt        <= '0;
            if (take_valid) begin
              target     <= take_mode;
              pend_valid <= 1'b0;
              vc_rstn_r  <= 1'b0;
              state      <= QUIESCE;
            end else begin
              busy_r <= 1'b0;
              state  <= IDLE;
            end
          end else if (cnt == T_LAST) begin
            cnt       <= '0;
            vc_rstn_r <= 1'b0;
            if (retry_inc < RTY_MAX) begin
              retry <= retry_inc;
              state <= QUIESCE;
            end else begin
              mode_err_r <= 1'b1;
              // A queued request restarts immediately rather than parking in ERROR.
              if (take_valid) begin
                target     <= take_mode;
                pend_valid <= 1'b0;
                retry      <= '0;
                state      <= QUIESCE;
              end else begin
                retry  <= retry_inc;
                busy_r <= 1'b0;
                state  <= ERROR;
              end
            end
          end else begin
            cnt    <= cnt + CNT_W'(1);
            stable <= bus.lock_i ? stable + STB_W'(1) : '0;
          end
        end

        ERROR: begin
          if (bus.mode_req_valid) begin
            target    <= bus.mode_req;
            retry     <= '0;
            cnt       <= '0;
            vc_rstn_r <= 1'b0;
            busy_r    <= 1'b1;
            state     <= QUIESCE;
          end
        end

        default: begin
          busy_r <= 1'b1;
          cnt    <= '0;
          state  <= QUIESCE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_video_mode_sequencer.sv
// Self-checking bench for video_mode_sequencer: emulated generator lock behaviour,
// randomized mode requests and a cycle-count reference model of each lock attempt.
module tb_video_mode_sequencer;
  localparam int QC = 4;
  localparam int SC = 8;
  localparam int LS = 16;
  localparam int TO = 100;
  localparam int MR = 2;

  logic clk27 = 1'b0;
  logic rstn  = 1'b0;

  video_mode_sequencer_if bus();

  video_mode_sequencer #(
    .DEFAULT_CONFIG(4'd0), .QUIESCE_CYCLES(QC), .SETTLE_CYCLES(SC),
    .LOCK_STABLE(LS), .LOCK_TIMEOUT(TO), .MAX_RETRY(MR), .CNT_W(8)
  ) dut (
    .clk27(clk27),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk27 = ~clk27;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Generator emulation: 0 never locks, 1 always locked, 2 locks lock_delay cycles after
  // release with a one-cycle dropout every glitch cycles, 3 manual level.
  int         lock_mode  = 1;
  int         lock_delay = 0;
  int         glitch     = 0;
  logic       lock_man   = 1'b1;
  int         hi_cnt     = 0;
  logic [3:0] cur        = 4'd0;

  function automatic logic lock_at(input int k);
    case (lock_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k > lock_delay) && !(glitch != 0 && (k % glitch) == 0);
      default: return lock_man;
    endcase
  endfunction

  // Cycle within the lock-wait window at which LS consecutive lock cycles complete, or 0 on timeout.
  function automatic int model_ack_cycle();
    int run = 0;
    for (int k = 1; k <= TO; k++) begin
      run = lock_at(k) ? run + 1 : 0;
      if (run >= LS) return k;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk27);
    #1;
    if (bus.vc_rstn === 1'b1) hi_cnt++;
    else hi_cnt = 0;
    bus.lock_i = lock_at(hi_cnt);
  endtask

  task automatic apply_stimulus(input logic [3:0] m);
    bus.mode_req       = m;
    bus.mode_req_valid = 1'b1;
    tick();
    bus.mode_req_valid = 1'b0;
  endtask

  function automatic logic [3:0] pick_mode();
    logic [3:0] m;
    do m = 4'($urandom_range(0, 15)); while (m == cur);
    return m;
  endfunction

  // Called with the DUT freshly in QUIESCE; follows one attempt to success or timeout.
  task automatic expect_attempt(input logic [3:0] cfg, input bit chg, output bit ok);
    int n, first, k;
    n = 0;
    first = -1;
    while (bus.vc_rstn !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (first < 0 && bus.clock_config === cfg) first = n;
    end
    check("release_time", n, QC + SC);
    if (chg) check("cfg_switch_time", first, QC);
    check("cfg_value", bus.clock_config, cfg);
    check("lock_lost_idle", bus.lock_lost, 0);
    k  = model_ack_cycle();
    ok = (k != 0);
    n  = 0;
    if (ok) begin
      while (bus.mode_ack !== 1'b1 && n < 150) begin tick(); n++; end
      check("ack_time", n, k);
      check("ack_busy", bus.busy, 0);
      check("ack_err", bus.mode_err, 0);
      check("ack_vc_rstn", bus.vc_rstn, 1);
      tick();
      check("ack_pulse", bus.mode_ack, 0);
    end else begin
      while (bus.vc_rstn !== 1'b0 && n < 150) begin tick(); n++; end
      check("timeout_time", n, TO);
      check("timeout_no_ack", bus.mode_ack, 0);
    end
  endtask

  task automatic check_output(input logic [3:0] cfg, input bit chg);
    bit ok;
    for (int a = 1; a <= MR; a++) begin
      expect_attempt(cfg, chg && a == 1, ok);
      if (ok) break;
      if (a < MR) begin
        check("retry_busy", bus.busy, 1);
      end else begin
        check("error_flag", bus.mode_err, 1);
        check("error_busy", bus.busy, 0);
      end
    end
  endtask

  initial begin
    logic [3:0] m;
    int n;
    bus.mode_req       = 4'd0;
    bus.mode_req_valid = 1'b0;
    bus.lock_i         = 1'b1;
    rstn = 1'b0;
    repeat (3) tick();
    check("rst_cfg", bus.clock_config, 0);
    check("rst_vc_rstn", bus.vc_rstn, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_ack", bus.mode_ack, 0);
    check("rst_err", bus.mode_err, 0);
    check("rst_lost", bus.lock_lost, 0);

    $display("[TB] power-up sequence");
    rstn = 1'b1;
    check_output(4'd0, 1'b0);

    $display("[TB] same-config request");
    apply_stimulus(cur);
    check("same_ack", bus.mode_ack, 1);
    check("same_busy", bus.busy, 0);
    tick();
    check("same_ack_pulse", bus.mode_ack, 0);
    check("same_vc_rstn", bus.vc_rstn, 1);

    $display("[TB] mode 3 with delayed lock");
    lock_mode = 2; lock_delay = 20; glitch = 0;
    apply_stimulus(4'd3);
    check_output(4'd3, 1'b1);
    cur = 4'd3;

    $display("[TB] randomized requests");
    for (int i = 0; i < 4; i++) begin
      m = pick_mode();
      lock_mode  = 2;
      lock_delay = int'($urandom_range(0, 50));
      glitch     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(17, 30)) : 0;
      apply_stimulus(m);
      check_output(m, 1'b1);
      cur = m;
    end
    lock_mode = 1;
    m = pick_mode();
    apply_stimulus(m);
    check_output(m, 1'b1);
    cur = m;

    $display("[TB] no lock, retries exhausted");
    lock_mode = 0;
    m = pick_mode();
    apply_stimulus(m);
    check_output(m, 1'b1);
    cur = m;
    repeat (5) tick();
    check("error_hold_err", bus.mode_err, 1);
    check("error_hold_busy", bus.busy, 0);
    check("error_hold_vc_rstn", bus.vc_rstn, 0);

    $display("[TB] periodic lock dropout");
    lock_mode = 2; lock_delay = 0; glitch = 10;
    m = pick_mode();
    apply_stimulus(m);
    check_output(m, 1'b1);
    cur = m;

    $display("[TB] recovery from error");
    lock_mode = 2; lock_delay = int'($urandom_range(0, 30)); glitch = 0;
    m = pick_mode();
    apply_stimulus(m);
    check_output(m, 1'b1);
    cur = m;

    $display("[TB] lock loss in idle");
    lock_mode = 3; lock_man = 1'b0; bus.lock_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("short_drop_lost", bus.lock_lost, 0);
    end
    lock_man = 1'b1; bus.lock_i = 1'b1;
    repeat (3) begin
      tick();
      check("short_drop_busy", bus.busy, 0);
    end
    lock_man = 1'b0; bus.lock_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("long_drop_early", bus.lock_lost, 0);
    end
    tick();
    check("lost_pulse", bus.lock_lost, 1);
    check("lost_busy", bus.busy, 1);
    check("lost_vc_rstn", bus.vc_rstn, 0);
    lock_mode = 1; bus.lock_i = 1'b1;
    check_output(cur, 1'b0);

    $display("[TB] requests while busy, latest wins");
    m = (cur == 4'd5) ? 4'd6 : 4'd5;
    apply_stimulus(m);
    n = 0;
    while (bus.mode_ack !== 1'b1 && n < 60) begin
      if (n == 1) begin bus.mode_req = 4'd1; bus.mode_req_valid = 1'b1; end
      else if (n == 3) begin bus.mode_req = 4'd2; bus.mode_req_valid = 1'b1; end
      else bus.mode_req_valid = 1'b0;
      tick();
      n++;
    end
    bus.mode_req_valid = 1'b0;
    check("pend_ack_time", n, QC + SC + LS);
    check("pend_cfg", bus.clock_config, m);
    check("pend_busy", bus.busy, 1);
    check("pend_vc_rstn", bus.vc_rstn, 0);
    check_output(4'd2, 1'b1);
    cur = 4'd2;

    $display("[TB] async reset mid-sequence");
    m = (cur == 4'd7) ? 4'd9 : 4'd7;
    apply_stimulus(m);
    repeat (6) tick();
    apply_stimulus(4'd4);
    rstn = 1'b0;
    #1;
    check("midrst_cfg", bus.clock_config, 0);
    check("midrst_vc_rstn", bus.vc_rstn, 0);
    check("midrst_busy", bus.busy, 1);
    check("midrst_ack", bus.mode_ack, 0);
    repeat (2) tick();
    rstn = 1'b1;
    check_output(4'd0, 1'b0);
    repeat (3) tick();
    check("midrst_no_pending", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
